// File: rtl/weight_load_ctrl_pkg.sv
// weight_load_ctrl_pkg: shared FSM states and bank geometry for the weight load sequencer
package weight_load_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, HOLD, REQ, RESP, DONE} state_t;
  localparam int N_TAPS_DEF = 25;
  localparam int W_ADDR_W = 10;
  localparam int W_DATA_W = 32;
endpackage

// File: rtl/weight_load_ctrl_cksum.sv
// wload_cksum: wrapping sum of written bank words, compared against an expected value when a load completes
module wload_cksum
  import weight_load_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                add,
  input  logic                fin,
  input  logic [W_DATA_W-1:0] data,
  input  logic [W_DATA_W-1:0] exp_sum,
  output logic [W_DATA_W-1:0] sum,
  output logic                err
);
  logic [W_DATA_W-1:0] nxt;
  // the final write lands in the same cycle as fin, so compare against the sum including it
  assign nxt = add ? sum + data : sum;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sum <= '0;
      err <= 1'b0;
    end else begin
      sum <= clr ? '0 : nxt;
      err <= clr ? 1'b0 : fin ? nxt != exp_sum : err;
    end
endmodule

// File: rtl/weight_load_ctrl.sv
// weight_load_ctrl: fills the 5x5 conv weight bank from weight memory, one read in flight at a time.
// Defining WLOAD_CKSUM_EN adds a running checksum of loaded words and a mismatch flag against cksum_exp.
module weight_load_ctrl
  import weight_load_ctrl_pkg::*;
#(
  parameter int N_TAPS    = N_TAPS_DEF,
  parameter int KID_W     = 4,
  parameter int MEM_AW    = 16,
  parameter int BASE_ADDR = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [KID_W-1:0]           kernel_id,
  input  logic                       conv_busy,
  output logic                       busy,
  output logic                       done,
  output logic                       mem_req,
  output logic [MEM_AW-1:0]          mem_addr,
  input  logic                       mem_gnt,
  input  logic                       mem_rvalid,
  input  logic [W_DATA_W-1:0]        mem_rdata,
  output logic                       w_wren,
  output logic [W_ADDR_W-1:0]        w_addr,
  output logic signed [W_DATA_W-1:0] w_data
`ifdef WLOAD_CKSUM_EN
  ,
  input  logic [W_DATA_W-1:0]        cksum_exp,
  output logic [W_DATA_W-1:0]        cksum,
  output logic                       cksum_err
`endif
);
  state_t state, state_n;
  logic [KID_W-1:0] kid;
  logic [W_ADDR_W-1:0] idx;
  logic accept, last, wr;
  assign accept = state == IDLE && start;
  assign last = idx == W_ADDR_W'(N_TAPS - 1);
  assign wr = state == RESP && mem_rvalid;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign mem_req = state == REQ;
  // MEM_AW-wide arithmetic gives the modulo-2^MEM_AW address wrap for free
  assign mem_addr = mem_req ? MEM_AW'(BASE_ADDR) + MEM_AW'(kid) * MEM_AW'(N_TAPS) + MEM_AW'(idx) : '0;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = conv_busy ? HOLD : REQ;
      HOLD:    if (!conv_busy) state_n = REQ;
      REQ:     if (mem_gnt) state_n = RESP;
      RESP:    if (mem_rvalid) state_n = last ? DONE : REQ;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      kid <= '0;
      idx <= '0;
      w_wren <= 1'b0;
      w_addr <= '0;
      w_data <= '0;
    end else begin
      state <= state_n;
      w_wren <= wr;
      if (accept) begin
        kid <= kernel_id;
        idx <= '0;
      end
      if (wr) begin
        w_addr <= idx;
        w_data <= mem_rdata;
        idx <= idx + 1'b1;
      end
    end
`ifdef WLOAD_CKSUM_EN
  wload_cksum u_cksum (
    .clk(clk), .rst(rst), .clr(accept), .add(w_wren), .fin(done),
    .data(w_data), .exp_sum(cksum_exp), .sum(cksum), .err(cksum_err)
  );
`endif
endmodule

// File: tb/tb_weight_load_ctrl.sv
// tb_weight_load_ctrl: randomized bench with a behavioural memory responder and address/data reference model.
// A second instance (MEM_AW=8, BASE_ADDR=250) shares all inputs to check address wrap.
module tb_weight_load_ctrl;
  logic clk = 0, rst = 0, start = 0, conv_busy = 0, mem_gnt = 0, mem_rvalid = 0;
  logic [3:0] kernel_id = '0;
  logic [31:0] mem_rdata = '0;
  logic busy, done, mem_req, w_wren, busy_b, done_b, mem_req_b, w_wren_b;
  logic [15:0] mem_addr;
  logic [7:0] mem_addr_b;
  logic [9:0] w_addr, w_addr_b;
  logic signed [31:0] w_data, w_data_b;
`ifdef WLOAD_CKSUM_EN
  logic [31:0] cksum_exp = '0, cksum, cksum_b;
  logic cksum_err, cksum_err_b;
`endif
  logic [61:0] oa;
  logic [53:0] ob;
  int tests = 0, fails = 0;
  assign oa = {busy, done, mem_req, mem_addr, w_wren, w_addr, w_data};
  assign ob = {busy_b, done_b, mem_req_b, mem_addr_b, w_wren_b, w_addr_b, w_data_b};

  weight_load_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .kernel_id(kernel_id), .conv_busy(conv_busy),
    .busy(busy), .done(done), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .w_wren(w_wren), .w_addr(w_addr), .w_data(w_data)
`ifdef WLOAD_CKSUM_EN
    , .cksum_exp(cksum_exp), .cksum(cksum), .cksum_err(cksum_err)
`endif
  );
  weight_load_ctrl #(.MEM_AW(8), .BASE_ADDR(250)) dut_b (
    .clk(clk), .rst(rst), .start(start), .kernel_id(kernel_id), .conv_busy(conv_busy),
    .busy(busy_b), .done(done_b), .mem_req(mem_req_b), .mem_addr(mem_addr_b), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .w_wren(w_wren_b), .w_addr(w_addr_b), .w_data(w_data_b)
`ifdef WLOAD_CKSUM_EN
    , .cksum_exp(cksum_exp), .cksum(cksum_b), .cksum_err(cksum_err_b)
`endif
  );

  always #5 clk = ~clk;

  // memory responder: random grant delay, then read data a random number of cycles later
  int gnt_max = 0, rv_min = 1, rv_max = 1, data_mode = 0, gcnt = -1, rcnt = 0;
  bit stray = 0, pend = 0;
  logic [15:0] paddr;
  logic [31:0] sent_q[$];
  initial forever begin
    @(posedge clk); #1;
    mem_gnt = 0; mem_rvalid = 0;
    if (!rst) begin
      pend = 0; gcnt = -1;
    end else if (pend) begin
      rcnt--;
      if (rcnt == 0) begin
        mem_rvalid = 1; pend = 0;
        mem_rdata = data_mode == 0 ? 32'(paddr) * 32'd3 : data_mode == 1 ? $urandom : 32'd1;
        sent_q.push_back(mem_rdata);
      end
    end else if (mem_req) begin
      if (gcnt < 0) gcnt = $urandom_range(gnt_max, 0);
      if (gcnt == 0) begin
        mem_gnt = 1; paddr = mem_addr; pend = 1; rcnt = $urandom_range(rv_max, rv_min);
      end
      gcnt--;
    end else if (stray) begin
      mem_gnt = 1'($urandom); mem_rvalid = 1'($urandom);
    end
  end

  // monitor: record requests, writes and done pulses away from the active edge
  int ecnt = 0, wb_n = 0, busy_n = 0, stab_viol = 0, out_viol = 0;
  int req_t[$], done_q[$];
  logic [15:0] req_a[$];
  logic [7:0] req_b[$];
  logic [9:0] wa_q[$];
  logic [31:0] wd_q[$];
  bit in_req = 0;
  logic [15:0] held = '0;
  always @(posedge clk) ecnt++;
  always @(negedge clk) begin
    if (mem_req) begin
      if (!in_req) begin
        req_t.push_back(ecnt); req_a.push_back(mem_addr); req_b.push_back(mem_addr_b);
      end else if (mem_addr !== held) stab_viol++;
      if (pend && !mem_gnt) out_viol++;
    end
    in_req = mem_req && !mem_gnt;
    held = mem_addr;
    if (w_wren) begin wa_q.push_back(w_addr); wd_q.push_back(w_data); end
    if (w_wren_b) wb_n++;
    if (done) done_q.push_back(ecnt);
    if (busy) busy_n++;
  end

  function automatic int exp_addr(int base, int kid, int k, int aw);
    return (base + kid * 25 + k) % (1 << aw);
  endfunction

  task automatic clr();
    req_t.delete(); req_a.delete(); req_b.delete(); wa_q.delete(); wd_q.delete();
    sent_q.delete(); done_q.delete();
    wb_n = 0; busy_n = 0; stab_viol = 0; out_viol = 0;
  endtask

  task automatic do_start(input logic [3:0] kid, output int a);
    @(posedge clk); #1;
    start = 1; kernel_id = kid; a = ecnt;
    @(posedge clk); #1;
    start = 0; kernel_id = 4'($urandom);
  endtask

  task automatic wait_done(input int n, input int lim, output bit ok);
    ok = 0;
    for (int i = 0; i < lim && !ok; i++) begin @(negedge clk); #1; ok = done_q.size() >= n; end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 0; #2;
    tests++;
    if (oa !== '0 || ob !== '0) begin fails++; $display("FAIL reset_outputs got=%h/%h want=0", oa, ob); end
    repeat (2) @(posedge clk); #1;
    rst = 1;
  endtask

  task automatic test_basic();
    int a; bit ok;
    gnt_max = 0; rv_min = 1; rv_max = 1; data_mode = 0; clr();
    do_start(4'd2, a);
    wait_done(1, 200, ok);
    tests++; if (!ok) begin fails++; $display("FAIL basic_timeout done_seen=%0b want=1", ok); end
    tests++; if (wa_q.size() != 25 || wb_n != 25) begin fails++; $display("FAIL basic_wren_count got=%0d/%0d want=25", wa_q.size(), wb_n); end
    for (int k = 0; k < 25; k++) begin
      tests++;
      if (k >= wa_q.size() || k >= req_a.size() || req_a[k] !== 16'(50 + k) || wa_q[k] !== 10'(k) || wd_q[k] !== 32'((50 + k) * 3)) begin
        fails++; $display("FAIL basic_tap%0d got addr=%0d w_addr=%0d w_data=%0d want %0d/%0d/%0d", k, req_a[k], wa_q[k], wd_q[k], 50 + k, k, (50 + k) * 3);
      end
    end
    tests++; if (done_q.size() != 1 || done_q[0] != a + 51) begin fails++; $display("FAIL basic_done_cycle got=%0d want=51", done_q.size() ? done_q[0] - a : -1); end
    tests++; if (busy_n != 51) begin fails++; $display("FAIL basic_busy_cycles got=%0d want=51", busy_n); end
  endtask

  task automatic test_hold();
    int a, h; bit ok;
    logic [3:0] kid;
    kid = 4'($urandom);
    gnt_max = 2; rv_min = 1; rv_max = 3; data_mode = 1; clr();
    conv_busy = 1;
    do_start(kid, a);
    repeat (9) @(posedge clk);
    #1;
    tests++; if (req_t.size() != 0 || busy !== 1'b1) begin fails++; $display("FAIL hold_no_req reqs=%0d busy=%0b want 0/1", req_t.size(), busy); end
    conv_busy = 0; h = ecnt;
    repeat (6) @(posedge clk);
    #1 conv_busy = 1;
    repeat (8) @(posedge clk);
    #1 conv_busy = 0;
    wait_done(1, 800, ok);
    tests++; if (!ok || wa_q.size() != 25) begin fails++; $display("FAIL hold_complete done=%0b writes=%0d want 1/25", ok, wa_q.size()); end
    tests++; if (req_t.size() == 0 || req_t[0] != h + 1) begin fails++; $display("FAIL hold_first_req got=%0d want=1 cycle after release", req_t.size() ? req_t[0] - h : -1); end
    for (int k = 0; k < 25; k++) begin
      tests++;
      if (k >= wa_q.size() || k >= req_a.size() || req_a[k] !== 16'(exp_addr(0, kid, k, 16)) || wa_q[k] !== 10'(k) || wd_q[k] !== sent_q[k]) begin
        fails++; $display("FAIL hold_tap%0d got addr=%0d w_addr=%0d w_data=%h want %0d/%0d/%h", k, req_a[k], wa_q[k], wd_q[k], exp_addr(0, kid, k, 16), k, sent_q[k]);
      end
    end
  endtask

  task automatic test_stall();
    int a; bit ok;
    logic [3:0] kid;
    for (int r = 0; r < 3; r++) begin
      kid = 4'($urandom);
      gnt_max = 5; rv_min = 1; rv_max = 4; data_mode = 1; clr();
      do_start(kid, a);
      wait_done(1, 2000, ok);
      tests++; if (!ok || wb_n != 25) begin fails++; $display("FAIL stall_complete done=%0b writes=%0d want 1/25", ok, wb_n); end
      tests++; if (stab_viol != 0 || out_viol != 0) begin fails++; $display("FAIL stall_handshake addr_changes=%0d extra_reqs=%0d want 0/0", stab_viol, out_viol); end
      for (int k = 0; k < 25; k++) begin
        tests++;
        if (k >= wa_q.size() || k >= req_a.size() || req_a[k] !== 16'(exp_addr(0, kid, k, 16)) || req_b[k] !== 8'(exp_addr(250, kid, k, 8))
            || wa_q[k] !== 10'(k) || wd_q[k] !== sent_q[k]) begin
          fails++; $display("FAIL stall_tap%0d got addr=%0d/%0d w_addr=%0d w_data=%h want %0d/%0d/%0d/%h", k, req_a[k], req_b[k], wa_q[k], wd_q[k],
                            exp_addr(0, kid, k, 16), exp_addr(250, kid, k, 8), k, sent_q[k]);
        end
      end
    end
  endtask

  task automatic test_boundary();
    int a; bit ok;
    clr(); stray = 1;
    repeat (12) @(posedge clk);
    #1 stray = 0;
    tests++; if (wa_q.size() != 0 || wb_n != 0 || req_t.size() != 0) begin fails++; $display("FAIL boundary_stray writes=%0d/%0d reqs=%0d want 0", wa_q.size(), wb_n, req_t.size()); end
    gnt_max = 1; rv_min = 1; rv_max = 2; data_mode = 1;
    do_start(4'd0, a);
    repeat (4) @(posedge clk);
    #1; start = 1; kernel_id = 4'd7;
    @(posedge clk); #1 start = 0;
    wait_done(1, 1000, ok);
    repeat (5) @(posedge clk);
    #1;
    tests++; if (!ok || done_q.size() != 1 || req_t.size() != 25 || busy !== 1'b0) begin
      fails++; $display("FAIL boundary_ignored_start dones=%0d reqs=%0d busy=%0b want 1/25/0", done_q.size(), req_t.size(), busy);
    end
    for (int k = 0; k < 25; k++) begin
      tests++;
      if (k >= req_b.size() || req_b[k] !== 8'((250 + k) % 256) || req_a[k] !== 16'(k) || wd_q[k] !== sent_q[k]) begin
        fails++; $display("FAIL boundary_tap%0d got addr=%0d/%0d want %0d/%0d", k, req_b[k], req_a[k], (250 + k) % 256, k);
      end
    end
  endtask

  task automatic test_reset_mid();
    int a; bit ok;
    gnt_max = 0; rv_min = 1; rv_max = 1; data_mode = 1; clr();
    do_start(4'd3, a);
    for (int i = 0; i < 200 && wa_q.size() < 12; i++) begin @(negedge clk); #1; end
    #2 rst = 0;
    #1;
    tests++; if (oa !== '0 || ob !== '0 || wa_q.size() != 12) begin fails++; $display("FAIL reset_mid_async got=%h/%h writes=%0d want 0/0/12", oa, ob, wa_q.size()); end
    repeat (2) @(posedge clk);
    #1;
    tests++; if (oa !== '0 || ob !== '0) begin fails++; $display("FAIL reset_mid_hold got=%h/%h want 0", oa, ob); end
    rst = 1; clr();
    do_start(4'd5, a);
    wait_done(1, 200, ok);
    tests++; if (!ok || done_q.size() != 1 || done_q[0] != a + 51 || wa_q.size() != 25) begin
      fails++; $display("FAIL reset_mid_reload done=%0b writes=%0d want 1/25", ok, wa_q.size());
    end
    for (int k = 0; k < 25; k++) begin
      tests++;
      if (k >= wa_q.size() || req_a[k] !== 16'(125 + k) || wa_q[k] !== 10'(k) || wd_q[k] !== sent_q[k]) begin
        fails++; $display("FAIL reset_mid_tap%0d got addr=%0d w_addr=%0d want %0d/%0d", k, req_a[k], wa_q[k], 125 + k, k);
      end
    end
  endtask

  task automatic test_back_to_back();
    int a; bit ok;
    gnt_max = 0; rv_min = 1; rv_max = 1; data_mode = 0; clr();
    @(posedge clk); #1;
    start = 1; kernel_id = 4'd1; a = ecnt;
    for (int i = 0; i < 300 && req_t.size() < 26; i++) begin @(negedge clk); #1; end
    start = 0;
    wait_done(2, 300, ok);
    tests++; if (!ok || done_q.size() != 2) begin fails++; $display("FAIL b2b_dones got=%0d want=2", done_q.size()); end
    tests++; if (done_q.size() < 2 || done_q[0] != a + 51 || done_q[1] != a + 103) begin fails++; $display("FAIL b2b_done_cycles got=%0d,%0d want=51,103", done_q[0] - a, done_q[1] - a); end
    tests++; if (req_t.size() < 26 || req_t[25] != a + 53 || req_a[25] !== 16'd25) begin fails++; $display("FAIL b2b_restart got cycle=%0d addr=%0d want 53/25", req_t[25] - a, req_a[25]); end
    tests++; if (busy_n != 102 || wa_q.size() != 50 || wd_q[49] !== 32'd147) begin fails++; $display("FAIL b2b_totals busy=%0d writes=%0d last=%0d want 102/50/147", busy_n, wa_q.size(), wd_q[49]); end
  endtask

`ifdef WLOAD_CKSUM_EN
  task automatic test_cksum();
    int a; bit ok;
    gnt_max = 1; rv_min = 1; rv_max = 2; data_mode = 2; clr(); cksum_exp = 32'd25;
    do_start(4'($urandom), a);
    wait_done(1, 1000, ok);
    tests++; if (!ok || cksum !== 32'd25 || cksum_err !== 1'b0 || cksum_b !== 32'd25 || cksum_err_b !== 1'b0) begin
      fails++; $display("FAIL cksum_match got=%0d err=%0b want 25/0", cksum, cksum_err);
    end
    clr(); cksum_exp = 32'd24;
    do_start(4'($urandom), a);
    wait_done(1, 1000, ok);
    tests++; if (!ok || cksum !== 32'd25 || cksum_err !== 1'b1) begin fails++; $display("FAIL cksum_mismatch got=%0d err=%0b want 25/1", cksum, cksum_err); end
    repeat (5) @(posedge clk);
    #1;
    tests++; if (cksum_err !== 1'b1 || cksum_err_b !== 1'b1) begin fails++; $display("FAIL cksum_err_hold got=%0b want 1", cksum_err); end
    clr(); cksum_exp = 32'd25;
    do_start(4'($urandom), a);
    tests++; if (cksum_err !== 1'b0 || cksum !== 32'd0) begin fails++; $display("FAIL cksum_clear got=%0d err=%0b want 0/0", cksum, cksum_err); end
    wait_done(1, 1000, ok);
    tests++; if (!ok || cksum_err !== 1'b0) begin fails++; $display("FAIL cksum_rerun err=%0b want 0", cksum_err); end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog sim time exceeded limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_stall();
    test_boundary();
    test_reset_mid();
    test_back_to_back();
`ifdef WLOAD_CKSUM_EN
    test_cksum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/weight_load_ctrl.md
Name: weight_load_ctrl

Overview:
Sequencer that fills the 25-tap 5x5 convolution weight register bank from a shared weight memory.
- On a start pulse it reads N_TAPS consecutive words for the selected kernel, one outstanding request at a time, using a req/gnt/rvalid handshake.
- Each returned word is written into the bank through its write-enable/address/data port.
- Loading is held off while the conv engine is busy, so weights never change mid-convolution.

Parameters:
N_TAPS, 25, number of weight words per kernel (bank address range 0..N_TAPS-1).
KID_W, 4, width of kernel_id.
MEM_AW, 16, weight memory address width.
BASE_ADDR, 0, memory word address of kernel 0, tap 0.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
start  in  1  load request; sampled only in IDLE
kernel_id  in  KID_W  kernel to load; latched when start is accepted
conv_busy  in  1  conv engine active; load waits while high
busy  out  1  high from the cycle after start is accepted through the DONE cycle
done  out  1  one-cycle pulse in the DONE state
mem_req  out  1  memory read request
mem_addr  out  MEM_AW  memory read address
mem_gnt  in  1  request accepted by the memory arbiter
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read data
w_wren  out  1  bank write enable (one-cycle pulse per tap)
w_addr  out  10  bank tap address
w_data  out  32  signed bank write data

Behaviour:
- Reset values: all outputs 0, state IDLE, idx 0, latched kernel_id 0.
- Reset mid-load aborts immediately to IDLE. Taps already written stay in the bank; this block does not clear the bank.
- All outputs are registered or Moore-decoded from the state register.
- FSM states: IDLE, HOLD, REQ, RESP, DONE.
- IDLE:
  - start=1 latches kernel_id and clears idx.
  - Goes to HOLD if conv_busy=1, else to REQ.
  - start while not in IDLE is ignored (no queuing).
- HOLD: wait until conv_busy=0, then go to REQ. conv_busy is only checked before the first request; once loading begins it is ignored.
- REQ:
  - mem_req=1.
  - mem_addr = BASE_ADDR + kid*N_TAPS + idx, computed modulo 2^MEM_AW (wrap, no error).
  - mem_addr is held stable until mem_gnt. On mem_gnt go to RESP.
- RESP:
  - mem_req=0; wait for mem_rvalid.
  - On mem_rvalid, the next cycle has w_wren=1, w_addr=idx, w_data=mem_rdata.
  - Then go to REQ with idx+1, or to DONE if idx==N_TAPS-1.
- Stray inputs: mem_rvalid outside RESP is ignored. mem_gnt outside REQ is ignored.
- DONE: done=1 for one cycle (coincides with the final w_wren), then IDLE.
- Best-case latency (gnt in the same cycle as req, rvalid one cycle later):
  - start accepted at cycle 0; tap k written at cycle 3+2k.
  - For N_TAPS=25: done at cycle 51, busy high cycles 1..51.
- Holding start high continuously back-to-back restarts a load in the cycle after DONE.

Optional Feature:
Macro WLOAD_CKSUM_EN.
- With it defined:
  - Extra input cksum_exp[31:0].
  - Extra outputs cksum[31:0] and cksum_err (1 bit).
  - cksum is cleared when start is accepted and accumulates every written w_data as a 32-bit wrapping sum.
  - In DONE, cksum_err is registered as (final sum != cksum_exp) and held until the next accepted start or reset.
- Without it: ports and logic are absent; the behaviour above is unchanged.

Decomposition:
- Shared package: FSM state enum (IDLE/HOLD/REQ/RESP/DONE), N_TAPS_DEF=25, W_ADDR_W=10, W_DATA_W=32.
- Sub-module wload_cksum (accumulator plus compare), instantiated only under WLOAD_CKSUM_EN. No other sub-modules.

Test Plan:
- Basic load:
  - Stimulus: kernel_id=2, BASE_ADDR=0, gnt in the same cycle as req, rvalid one cycle later, rdata=addr*3.
  - Required: mem_addr 50..74 in order; w_addr 0..24 with w_data 150..222; done at cycle 51; exactly 25 w_wren pulses.
- Hold-off:
  - Stimulus: conv_busy=1 for 10 cycles after start.
  - Required: no mem_req while conv_busy=1; first mem_req in the cycle after conv_busy falls. A conv_busy re-assertion mid-load does not stall the load.
- Arbiter stall:
  - Stimulus: mem_gnt delayed 0..5 random cycles and mem_rvalid delayed 1..4 random cycles.
  - Required: mem_addr stable while req is high without gnt; single outstanding request; correct w_addr/w_data pairing.
- Boundary:
  - Stimulus: MEM_AW=8, BASE_ADDR=250, kernel_id=0.
  - Required: addresses 250..255 then 0..18 (wrap); stray rvalid/gnt in IDLE produce no writes; a start pulse during busy is ignored.
- Reset mid-load:
  - Stimulus: rst low at tap 12.
  - Required: all outputs 0 asynchronously, state IDLE; a new start performs a full 25-tap load.
- Checksum (WLOAD_CKSUM_EN):
  - Stimulus: all rdata=1, first with cksum_exp=25, then with cksum_exp=24.
  - Required: cksum=25 and cksum_err=0 in the first run; cksum_err=1 in the second run, holding until the next start.
